// File: rtl/fuel_trip_sequencer_if.sv
// Segment request channel between the mileage-averaging stage and the
// fuel-trip sequencer.
//
// Handshake: a segment transfers on a rising clk edge where seg_valid and
// seg_ready are both 1. The master holds distance/avg_mileage stable while
// seg_valid is high and it has not been accepted yet. seg_ready may depend
// combinationally on sequencer state and tank_load, but never on seg_valid.
//
// Signals:
//   seg_valid    master -> slave  segment request valid
//   seg_ready    slave  -> master sequencer can take a segment this cycle
//   distance     master -> slave  segment distance (dividend)
//   avg_mileage  master -> slave  segment average mileage (divisor)
interface fuel_trip_sequencer_if #(
  parameter int DIST_W = 4,
  parameter int MIL_W  = 8
);
  logic              seg_valid;
  logic              seg_ready;
  logic [DIST_W-1:0] distance;
  logic [MIL_W-1:0]  avg_mileage;

  modport master (
    output seg_valid,
    output distance,
    output avg_mileage,
    input  seg_ready
  );

  modport slave (
    input  seg_valid,
    input  distance,
    input  avg_mileage,
    output seg_ready
  );
endinterface

// File: rtl/fuel_trip_sequencer.sv
// Fuel-gauge sequencer. It takes trip segments (distance, avg_mileage) and
// divides them with a shared 1-bit/cycle restoring divider
// (fuel_used = distance / avg_mileage). It then updates remaining fuel, the
// accumulated consumption and the low/critical fuel LEDs.
//
// Ports:
//   clk                  in   rising-edge system clock
//   reset_n              in   asynchronous active-low reset
//   tank_load            in   pulse: load input_fuel as tank level (IDLE only)
//   input_fuel           in   tank level to load
//   seg                  slave modport of fuel_trip_sequencer_if
//   busy                 out  sequencer not in IDLE
//   done                 out  one-cycle pulse, segment results updated
//   fuel_used            out  quotient of the last segment
//   remaining_fuel       out  current tank level, floors at 0
//   total_fuel_consumed  out  fuel used since last tank_load, saturating
//   div_err              out  sticky: a segment had avg_mileage == 0
//   LED1                 out  low-fuel warning  (CRIT_TH < remaining <= LOW_TH)
//   LED2                 out  critical warning  (remaining <= CRIT_TH)
//   state_dbg            out  current FSM state encoding
module fuel_trip_sequencer #(
  parameter int FUEL_W  = 5,
  parameter int DIST_W  = 4,
  parameter int MIL_W   = 8,
  parameter int LOW_TH  = 5,
  parameter int CRIT_TH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tank_load,
  input  logic [FUEL_W-1:0] input_fuel,
  fuel_trip_sequencer_if.slave seg,
  output logic              busy,
  output logic              done,
  output logic [DIST_W-1:0] fuel_used,
  output logic [FUEL_W-1:0] remaining_fuel,
  output logic [FUEL_W-1:0] total_fuel_consumed,
  output logic              div_err,
  output logic              LED1,
  output logic              LED2,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = (DIST_W > 1) ? $clog2(DIST_W) : 1;
  // Arithmetic width wide enough for either operand plus one carry bit.
  localparam int SUM_W = ((FUEL_W > DIST_W) ? FUEL_W : DIST_W) + 1;
  localparam logic [FUEL_W-1:0] LOW_V  = FUEL_W'(LOW_TH);
  localparam logic [FUEL_W-1:0] CRIT_V = FUEL_W'(CRIT_TH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DIST_W-1:0] dist_q;
  logic [MIL_W-1:0]  div_q;
  logic [MIL_W:0]    rem_q;
  logic [DIST_W-1:0] quo_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept;
  logic [MIL_W:0]    trial;
  logic              trial_ge;
  logic [MIL_W:0]    trial_diff;
  logic [SUM_W-1:0]  rem_ext;
  logic [SUM_W-1:0]  tot_ext;
  logic [SUM_W-1:0]  quo_ext;
  logic [SUM_W-1:0]  sum_ext;
  logic [FUEL_W-1:0] new_rem;
  logic [FUEL_W-1:0] new_total;

  function automatic logic led_crit(input logic [FUEL_W-1:0] v);
    return (v <= CRIT_V);
  endfunction

  function automatic logic led_low(input logic [FUEL_W-1:0] v);
    return (v > CRIT_V) && (v <= LOW_V);
  endfunction

  // tank_load wins over a pending segment in IDLE, so ready drops with it.
  assign seg.seg_ready = (state == S_IDLE) && !tank_load;
  assign accept        = seg.seg_valid && seg.seg_ready;
  assign busy          = (state != S_IDLE);
  assign state_dbg     = state;

  // Restoring divider step: shift in the next dividend bit (MSB first) and
  // subtract the divisor when it fits. The remainder always stays below the
  // divisor, so its top bit is free to absorb the shift.
  always_comb begin
    trial      = {rem_q[MIL_W-1:0], dist_q[cnt_q]};
    trial_ge   = (trial >= {1'b0, div_q});
    trial_diff = trial - {1'b0, div_q};
  end

  // Segment result arithmetic: remaining floors at 0, total clamps at max.
  always_comb begin
    rem_ext = SUM_W'(remaining_fuel);
    tot_ext = SUM_W'(total_fuel_consumed);
    quo_ext = SUM_W'(quo_q);
    sum_ext = tot_ext + quo_ext;
    new_rem = '0;
    if (rem_ext >= quo_ext) begin
      new_rem = FUEL_W'(rem_ext - quo_ext);
    end
    new_total = FUEL_W'(sum_ext);
    if (|sum_ext[SUM_W-1:FUEL_W]) begin
      new_total = '1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          // A zero divisor skips the divider entirely.
          state_nxt = (seg.avg_mileage == '0) ? S_UPDATE : S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        if (cnt_q == '0) begin
          state_nxt = S_UPDATE;
        end
      end
      S_UPDATE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dist_q              <= '0;
      div_q               <= '0;
      rem_q               <= '0;
      quo_q               <= '0;
      cnt_q               <= '0;
      done                <= 1'b0;
      fuel_used           <= '0;
      remaining_fuel      <= '0;
      total_fuel_consumed <= '0;
      div_err             <= 1'b0;
      LED1                <= 1'b0;
      LED2                <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tank_load) begin
            remaining_fuel      <= input_fuel;
            total_fuel_consumed <= '0;
            div_err             <= 1'b0;
            LED1                <= led_low(input_fuel);
            LED2                <= led_crit(input_fuel);
          end else if (accept) begin
            dist_q <= seg.distance;
            div_q  <= seg.avg_mileage;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= CNT_W'(DIST_W - 1);
          end
        end
        S_DIVIDE: begin
          if (trial_ge) begin
            rem_q        <= trial_diff;
            quo_q[cnt_q] <= 1'b1;
          end else begin
            rem_q <= trial;
          end
          cnt_q <= cnt_q - 1'b1;
        end
        S_UPDATE: begin
          fuel_used           <= quo_q;
          remaining_fuel      <= new_rem;
          total_fuel_consumed <= new_total;
          LED1                <= led_low(new_rem);
          LED2                <= led_crit(new_rem);
          if (div_q == '0) begin
            div_err <= 1'b1;
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fuel_trip_sequencer.sv
// Directed bench for fuel_trip_sequencer. Every task starts and ends at a
// falling clock edge; inputs change there and outputs are sampled there.
// Latency k means done is first seen high just before rising edge T+k,
// where T is the accept edge.
module tb_fuel_trip_sequencer;

  logic       clk;
  logic       reset_n;
  logic       tank_load;
  logic [4:0] input_fuel;
  logic       busy;
  logic       done;
  logic [3:0] fuel_used;
  logic [4:0] remaining_fuel;
  logic [4:0] total_fuel_consumed;
  logic       div_err;
  logic       LED1;
  logic       LED2;
  logic [1:0] state_dbg;

  int checks = 0;
  int passes = 0;

  fuel_trip_sequencer_if #(.DIST_W(4), .MIL_W(8)) seg_bus ();

  fuel_trip_sequencer dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .tank_load           (tank_load),
    .input_fuel          (input_fuel),
    .seg                 (seg_bus.slave),
    .busy                (busy),
    .done                (done),
    .fuel_used           (fuel_used),
    .remaining_fuel      (remaining_fuel),
    .total_fuel_consumed (total_fuel_consumed),
    .div_err             (div_err),
    .LED1                (LED1),
    .LED2                (LED2),
    .state_dbg           (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] fu, input logic [4:0] rem,
                         input logic [4:0] tot, input logic l1, input logic l2,
                         input logic de);
    chk({tag, "_fuel_used"}, 32'(fuel_used), 32'(fu));
    chk({tag, "_remaining"}, 32'(remaining_fuel), 32'(rem));
    chk({tag, "_total"}, 32'(total_fuel_consumed), 32'(tot));
    chk({tag, "_led1"}, 32'(LED1), 32'(l1));
    chk({tag, "_led2"}, 32'(LED2), 32'(l2));
    chk({tag, "_div_err"}, 32'(div_err), 32'(de));
  endtask

  // driver: one-cycle tank_load pulse
  task automatic load(input logic [4:0] f);
    tank_load  = 1'b1;
    input_fuel = f;
    @(negedge clk);
    tank_load  = 1'b0;
  endtask

  // driver: offer one segment, scramble the inputs after accept, optionally
  // pulse tank_load at falling edge load_at while busy, and wait for done.
  task automatic run_seg(input string tag, input logic [3:0] d, input logic [7:0] m,
                         input int exp_k, input int load_at, input logic [4:0] load_val);
    int  k;
    bit  seen;
    seg_bus.seg_valid   = 1'b1;
    seg_bus.distance    = d;
    seg_bus.avg_mileage = m;
    #1;
    chk({tag, "_ready"}, 32'(seg_bus.seg_ready), 32'd1);
    @(posedge clk);
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        seg_bus.seg_valid   = 1'b0;
        seg_bus.distance    = 4'($urandom_range(0, 15));
        seg_bus.avg_mileage = 8'($urandom_range(1, 255));
      end
      if (load_at != 0 && k == load_at) begin
        tank_load  = 1'b1;
        input_fuel = load_val;
      end else begin
        tank_load = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    chk({tag, "_latency"}, 32'(k), 32'(exp_k));
  endtask

  initial begin
    int done_cnt;
    reset_n             = 1'b0;
    tank_load           = 1'b0;
    input_fuel          = '0;
    seg_bus.seg_valid   = 1'b0;
    seg_bus.distance    = '0;
    seg_bus.avg_mileage = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_out("rst", 4'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: load 20, 12/3 -> 4
    load(5'd20);
    chk_out("load20", 4'd0, 5'd20, 5'd0, 1'b0, 1'b0, 1'b0);
    run_seg("seg1", 4'd12, 8'd3, 6, 0, 5'd0);
    chk_out("seg1", 4'd4, 5'd16, 5'd4, 1'b0, 1'b0, 1'b0);

    // 2: back-to-back, 15/1 -> 15
    run_seg("seg2", 4'd15, 8'd1, 6, 0, 5'd0);
    chk_out("seg2", 4'd15, 5'd1, 5'd19, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("done_pulse_width", 32'(done), 32'd0);

    // 3: 15/5 -> 3, remaining floors at 0; reload 4 gives LED1
    run_seg("seg3", 4'd15, 8'd5, 6, 0, 5'd0);
    chk_out("seg3", 4'd3, 5'd0, 5'd22, 1'b0, 1'b1, 1'b0);
    load(5'd4);
    chk_out("load4", 4'd3, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0);

    // 4: zero divisor, short latency, sticky div_err cleared by load
    run_seg("seg4", 4'd9, 8'd0, 2, 0, 5'd0);
    chk_out("seg4", 4'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1);
    load(5'd10);
    chk_out("load10", 4'd0, 5'd10, 5'd0, 1'b0, 1'b0, 1'b0);

    // 5: tank_load and seg_valid in the same IDLE cycle
    tank_load           = 1'b1;
    input_fuel          = 5'd25;
    seg_bus.seg_valid   = 1'b1;
    seg_bus.distance    = 4'd8;
    seg_bus.avg_mileage = 8'd2;
    #1;
    chk("prio_ready", 32'(seg_bus.seg_ready), 32'd0);
    @(negedge clk);
    tank_load = 1'b0;
    chk("prio_busy", 32'(busy), 32'd0);
    chk("prio_remaining", 32'(remaining_fuel), 32'd25);
    run_seg("seg5", 4'd8, 8'd2, 6, 0, 5'd0);
    chk_out("seg5", 4'd4, 5'd21, 5'd4, 1'b0, 1'b0, 1'b0);

    // total saturates at 31, remaining floors at 0
    load(5'd31);
    run_seg("sat1", 4'd15, 8'd1, 6, 0, 5'd0);
    chk_out("sat1", 4'd15, 5'd16, 5'd15, 1'b0, 1'b0, 1'b0);
    run_seg("sat2", 4'd15, 8'd1, 6, 0, 5'd0);
    chk_out("sat2", 4'd15, 5'd1, 5'd30, 1'b0, 1'b1, 1'b0);
    run_seg("sat3", 4'd15, 8'd1, 6, 0, 5'd0);
    chk_out("sat3", 4'd15, 5'd0, 5'd31, 1'b0, 1'b1, 1'b0);

    // 6a: tank_load while busy is dropped
    load(5'd10);
    run_seg("busyload", 4'd12, 8'd3, 6, 3, 5'd7);
    chk_out("busyload", 4'd4, 5'd6, 5'd4, 1'b0, 1'b0, 1'b0);

    // 6b: reset two cycles after accept aborts, no done afterwards
    seg_bus.seg_valid   = 1'b1;
    seg_bus.distance    = 4'd12;
    seg_bus.avg_mileage = 8'd3;
    @(posedge clk);
    @(negedge clk);
    seg_bus.seg_valid = 1'b0;
    chk("abort_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_state", 32'(state_dbg), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk_out("abort", 4'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
